// File: rtl/seven_seg_reader.sv
// ---------------------------------------------------------------------------
// seven_seg_reader
//
// Monitors a multiplexed seven-segment display bus and recovers the hex digit
// and position being shown. The bus is synchronised and debounced; each stable
// pattern is decoded once, and accepted digits are assembled into a 32-bit
// frame (nibble i = last digit seen at position i).
//
// Optional feature macro: SEG_READER_ERR_EN
//   defined   -> 'err' port present, pulses on multi-anode / illegal patterns
//   undefined -> 'err' port absent, such patterns are dropped silently
//
// Parameters
//   STABLE_CYCLES : consecutive identical synchronised samples needed (1..255)
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   seg_a..seg_g        : segment lines, active low
//   an_0..an_7          : anode lines, active low
//   digit_out, pos_out  : last accepted digit and its position
//   valid               : one-cycle pulse when digit_out/pos_out update
//   frame_out           : assembled 8-digit frame
//   frame_done          : one-cycle pulse when all 8 positions were written
//   err                 : one-cycle pulse on rejected evaluation (optional)
// ---------------------------------------------------------------------------
module seven_seg_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seg_a,
   input  logic        seg_b,
   input  logic        seg_c,
   input  logic        seg_d,
   input  logic        seg_e,
   input  logic        seg_f,
   input  logic        seg_g,
   input  logic        an_0,
   input  logic        an_1,
   input  logic        an_2,
   input  logic        an_3,
   input  logic        an_4,
   input  logic        an_5,
   input  logic        an_6,
   input  logic        an_7,
   output logic [3:0]  digit_out,
   output logic [2:0]  pos_out,
   output logic        valid,
   output logic [31:0] frame_out,
   output logic        frame_done
`ifdef SEG_READER_ERR_EN
   ,
   output logic        err
`endif
);

   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   // bus layout: [14:7] anodes 7..0, [6:0] segments a..g (a is bit 6)
   logic [14:0] bus;
   logic [14:0] sync1;
   logic [14:0] s;
   logic [14:0] p;

   state_t      state, state_next;
   logic [7:0]  count, count_next;
   logic        eval;

   logic [7:0]  an_sel;
   logic [6:0]  seg_lit;
   logic [3:0]  dec_digit;
   logic        dec_legal;
   logic [2:0]  pos_idx;
   logic        one_hot;
   logic        accept;
   logic [7:0]  seen;
   logic [7:0]  seen_set;

   assign bus = {an_7, an_6, an_5, an_4, an_3, an_2, an_1, an_0,
                 seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

   assign an_sel  = ~s[14:7];
   assign seg_lit = ~s[6:0];

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Next state: any change restarts the stability count, regardless of state.
   always_comb begin
      state_next = state;
      count_next = count;
      eval       = 1'b0;
      if (s != p) begin
         count_next = '0;
         state_next = (&s[14:7]) ? IDLE : SETTLE;
      end else begin
         case (state)
            SETTLE: begin
               count_next = count + 8'd1;
               if (count + 8'd1 == STABLE_LIM) begin
                  eval       = 1'b1;
                  state_next = HOLD;
               end
            end
            default: ; // IDLE and HOLD wait for a change; counter holds
         endcase
      end
   end

   // Segment pattern -> hex value
   always_comb begin
      dec_digit = 4'h0;
      dec_legal = 1'b1;
      case (seg_lit)
         7'h7E: dec_digit = 4'h0;
         7'h30: dec_digit = 4'h1;
         7'h6D: dec_digit = 4'h2;
         7'h79: dec_digit = 4'h3;
         7'h33: dec_digit = 4'h4;
         7'h5B: dec_digit = 4'h5;
         7'h5F: dec_digit = 4'h6;
         7'h70: dec_digit = 4'h7;
         7'h7F: dec_digit = 4'h8;
         7'h7B: dec_digit = 4'h9;
         7'h77: dec_digit = 4'hA;
         7'h1F: dec_digit = 4'hB;
         7'h4E: dec_digit = 4'hC;
         7'h3D: dec_digit = 4'hD;
         7'h4F: dec_digit = 4'hE;
         7'h47: dec_digit = 4'hF;
         default: dec_legal = 1'b0;
      endcase
   end

   // Anode index (only meaningful when exactly one anode is selected)
   always_comb begin
      pos_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (an_sel[i]) pos_idx = 3'(i);
      end
   end

   assign one_hot  = $onehot(an_sel);
   assign accept   = eval & one_hot & dec_legal;
   assign seen_set = seen | (8'd1 << pos_idx);

   // Synchroniser, previous-sample register and output datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1      <= '1;
         s          <= '1;
         p          <= '1;
         digit_out  <= '0;
         pos_out    <= '0;
         valid      <= 1'b0;
         frame_out  <= '0;
         frame_done <= 1'b0;
         seen       <= '0;
      end else begin
         sync1      <= bus;
         s          <= sync1;
         p          <= s;
         valid      <= accept;
         frame_done <= 1'b0;
         if (accept) begin
            digit_out                     <= dec_digit;
            pos_out                       <= pos_idx;
            frame_out[{pos_idx, 2'b00} +: 4] <= dec_digit;
            // completing the set of positions starts a fresh frame
            if (seen_set == 8'hFF) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen       <= seen_set;
            end
         end
      end
   end

`ifdef SEG_READER_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else begin
         err <= eval & ~accept;
      end
   end
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_reader
//
// Self-checking bench for seven_seg_reader. Stimulus pushes the expected
// accepted digit (value, position, frame, frame_done, arrival edge) into a
// scoreboard queue; a monitor pops and compares on every valid pulse.
// ---------------------------------------------------------------------------
module tb_seven_seg_reader;

   localparam int STABLE = 4;

   typedef struct {
      logic [3:0]  digit;
      logic [2:0]  pos;
      logic [31:0] frame;
      logic        fdone;
      int          at;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = 7'h7F;   // [6]=a .. [0]=g, active low
   logic [7:0]  an  = 8'hFF;   // active low
   logic [3:0]  digit_out;
   logic [2:0]  pos_out;
   logic        valid;
   logic [31:0] frame_out;
   logic        frame_done;
`ifdef SEG_READER_ERR_EN
   logic        err;
`endif

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          edge_cnt = 0;
   int          err_cnt  = 0;
   int          exp_err  = 0;

   // bench model of the visible output state
   logic [3:0]  m_digit = '0;
   logic [2:0]  m_pos   = '0;
   logic [31:0] m_frame = '0;
   logic [7:0]  m_seen  = '0;

   seven_seg_reader #(.STABLE_CYCLES(STABLE)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_a      (seg[6]),
      .seg_b      (seg[5]),
      .seg_c      (seg[4]),
      .seg_d      (seg[3]),
      .seg_e      (seg[2]),
      .seg_f      (seg[1]),
      .seg_g      (seg[0]),
      .an_0       (an[0]),
      .an_1       (an[1]),
      .an_2       (an[2]),
      .an_3       (an[3]),
      .an_4       (an[4]),
      .an_5       (an[5]),
      .an_6       (an[6]),
      .an_7       (an[7]),
      .digit_out  (digit_out),
      .pos_out    (pos_out),
      .valid      (valid),
      .frame_out  (frame_out),
      .frame_done (frame_done)
`ifdef SEG_READER_ERR_EN
      ,
      .err        (err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // lit-segment set for each hex value, a..g as bits 6..0
   function automatic logic [6:0] lit_of(input logic [3:0] d);
      case (d)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   function automatic logic [2:0] idx_of(input logic [7:0] sel);
      logic [2:0] r = '0;
      for (int i = 0; i < 8; i++) if (sel[i]) r = 3'(i);
      return r;
   endfunction

   // Drive one bus pattern and hold it. ok=1: a legal single-anode digit that
   // must be accepted once. ok=0: must not produce valid.
   task automatic apply(input logic [6:0] lit, input logic [7:0] sel,
                        input int cycles, input bit ok, input bit push);
      exp_t e;
      @(negedge clk);
      seg = ~lit;
      an  = ~sel;
      if (ok && push) begin
         m_digit = (lit == lit_of(4'h0)) ? 4'h0 : m_digit;
         for (int d = 0; d < 16; d++) if (lit_of(4'(d)) == lit) m_digit = 4'(d);
         m_pos = idx_of(sel);
         m_frame[{m_pos, 2'b00} +: 4] = m_digit;
         m_seen = m_seen | (8'd1 << m_pos);
         e.fdone = (m_seen == 8'hFF);
         if (e.fdone) m_seen = '0;
         e.digit = m_digit;
         e.pos   = m_pos;
         e.frame = m_frame;
         e.at    = edge_cnt + STABLE + 3;
         sb.push_back(e);
         $display("drive digit=%0h pos=%0d expect frame=%08h fdone=%0b", e.digit, e.pos, e.frame, e.fdone);
      end else if (!ok && sel != 8'h00) begin
         exp_err++;
         $display("drive reject pattern lit=%02h an_sel=%02h", lit, sel);
      end else if (!ok) begin
         $display("drive idle bus");
      end
      repeat (cycles) @(negedge clk);
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_digit"}, 32'(digit_out), 32'(m_digit));
      check({tag, "_pos"},   32'(pos_out),   32'(m_pos));
      check({tag, "_frame"}, frame_out,      m_frame);
   endtask

   // scoreboard monitor, sampling away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(digit_out), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("digit_out",  32'(digit_out),  32'(e.digit));
               check("pos_out",    32'(pos_out),    32'(e.pos));
               check("frame_out",  frame_out,       e.frame);
               check("frame_done", 32'(frame_done), 32'(e.fdone));
               check("latency",    32'(edge_cnt),   32'(e.at));
               $display("valid digit=%0h pos=%0d frame=%08h fdone=%0b", digit_out, pos_out, frame_out, frame_done);
            end
         end else if (frame_done) begin
            check("stray_frame_done", 32'(frame_done), 32'h0);
         end
`ifdef SEG_READER_ERR_EN
         if (err) begin
            err_cnt++;
            check("err_with_frame_done", 32'(frame_done), 32'h0);
         end
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      check("rst_digit", 32'(digit_out), 32'h0);
      check("rst_pos",   32'(pos_out),   32'h0);
      check("rst_valid", 32'(valid),     32'h0);
      check("rst_frame", frame_out,      32'h0);
      check("rst_fdone", 32'(frame_done), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single digit "5" at position 3
      apply(lit_of(4'h5), 8'b0000_1000, 10, 1, 1);
      check("t1_frame", frame_out, 32'h0000_5000);
      check_hold("t1");

      // scan positions 0..7 with digits 0..7
      for (int i = 0; i < 8; i++) apply(lit_of(4'(i)), 8'd1 << i, 10, 1, 1);
      check("scan_frame", frame_out, 32'h7654_3210);
      check("scan_seen_model", 32'(m_seen), 32'h0);
      check_hold("scan");

      // glitch to "8" for 2 cycles, then back: original re-accepted once
      apply(lit_of(4'hA), 8'b0000_0100, 10, 1, 1);
      apply(lit_of(4'h8), 8'b0000_0100, 2, 0, 0);
      exp_err = exp_err - 1; // a short glitch is never evaluated
      apply(lit_of(4'hA), 8'b0000_0100, 10, 1, 1);
      check_hold("glitch");

      // two anodes low, illegal "abg", all-dark with one anode
      apply(lit_of(4'h3), 8'b0000_0110, 10, 0, 0);
      check_hold("multi_anode");
      apply(7'b1100001, 8'b0001_0000, 10, 0, 0);
      check_hold("illegal_abg");
      apply(7'b0000000, 8'b0100_0000, 10, 0, 0);
      check_hold("all_dark");

      // idle bus, then return to a previously accepted pattern
      apply(7'h00, 8'h00, 10, 0, 0);
      apply(lit_of(4'hA), 8'b0000_0100, 10, 1, 1);
      apply(lit_of(4'hF), 8'b1000_0000, 10, 1, 1);
      check_hold("return");

      // reset two cycles into SETTLE
      apply(lit_of(4'hA), 8'b0010_0000, 5, 0, 0);
      exp_err = exp_err - 1; // killed by reset before evaluation
      rst = 1'b1;
      #1;
      check("mid_rst_digit", 32'(digit_out),  32'h0);
      check("mid_rst_pos",   32'(pos_out),    32'h0);
      check("mid_rst_valid", 32'(valid),      32'h0);
      check("mid_rst_frame", frame_out,       32'h0);
      check("mid_rst_fdone", 32'(frame_done), 32'h0);
      m_digit = '0; m_pos = '0; m_frame = '0; m_seen = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      begin
         exp_t e;
         e.digit = 4'hA; e.pos = 3'd5; e.frame = 32'h00A0_0000; e.fdone = 1'b0;
         e.at = edge_cnt + STABLE + 3;
         sb.push_back(e);
         m_digit = 4'hA; m_pos = 3'd5; m_frame = 32'h00A0_0000; m_seen = 8'h20;
         $display("release reset expect digit=a pos=5 frame=00a00000");
      end
      repeat (12) @(negedge clk);
      check_hold("post_rst");

      // drain
      repeat (20) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'h0);
`ifdef SEG_READER_ERR_EN
      check("err_count", 32'(err_cnt), 32'(exp_err));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
